uart_rx: RTL and testbench

Serial UART receiver with 16× oversampling. It recovers asynchronous 8N1-style frames (DBIT data bits, LSB first, one stop bit of SB_TICK ticks) from the `rx` pin and presents each byte on `dout` with a one-cycle `rx_done_tick`. It shares the baud-rate tick generator (`s_tick`) and frame format with `uart_tx`, and is the receive half of the debug/load UART link of the MIPS core.

---
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver (DBIT data bits LSB first, SB_TICK-tick stop bit).
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each decision tick.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err
);

  // Stop bits longer than 16 ticks need one more counter bit.
  localparam int SW = (SB_TICK > 16) ? 5 : 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [SW-1:0] s;
  logic [2:0]    n;
  logic [7:0]    b;
  logic [7:0]    b_shift;
  logic          rx_meta;
  logic          rx_s;
  logic          smp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist holds rx_s from the two ticks before the current one (counts c-2, c-1).
  logic [1:0] hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= 2'b11;
    end else if (s_tick) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign smp = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign smp = rx_s;
`endif

  always_comb begin
    b_shift         = b >> 1;
    b_shift[DBIT-1] = smp;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      dout         <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == SW'(7)) begin
              // A start bit that is high again at its centre was a glitch.
              if (!smp) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == SW'(15)) begin
              s <= '0;
              b <= b_shift;
              if (n == 3'(DBIT - 1)) begin
                state <= STOP;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == SW'(SB_TICK - 1)) begin
              dout         <= b;
              frame_err    <= !smp;
              rx_done_tick <= 1'b1;
              state        <= IDLE;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: s_tick every 4 clocks, frames driven tick by tick.
module tb_uart_rx;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       s_tick;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;

  int         vector_count;
  int         miscompare_count;
  int         pulse_count;
  logic [7:0] last_dout;
  logic       last_err;
  longint     pulse_time;
  longint     t0;
  int         tick_phase;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-clock s_tick every fourth cycle, changed on the falling edge.
  initial begin
    s_tick     = 1'b0;
    tick_phase = 0;
    forever begin
      @(negedge clk);
      tick_phase = (tick_phase + 1) % 4;
      s_tick = (tick_phase == 0);
    end
  end

  initial begin
    pulse_count = 0;
    last_dout   = 8'h00;
    last_err    = 1'b0;
    pulse_time  = 0;
    forever begin
      @(negedge clk);
      if (rx_done_tick === 1'b1) begin
        pulse_count = pulse_count + 1;
        last_dout   = dout;
        last_err    = frame_err;
        pulse_time  = longint'($time);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vector_count = vector_count + 1;
    if (observed !== expected) begin
      miscompare_count = miscompare_count + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitTick();
    do @(posedge clk); while (s_tick !== 1'b1);
  endtask

  task automatic idleTicks(input int count);
    for (int i = 0; i < count; i++) waitTick();
  endtask

  // Tick 0 drives the start edge; bit k of the frame occupies ticks 16k..16k+15.
  task automatic applyStimulus(input logic [7:0] data, input bit stop_low,
                               input int corrupt_tick, input int abort_tick);
    logic lvl;
    waitTick();
    t0 = longint'($time);
    #1 rx = 1'b0;
    for (int t = 1; t < 160; t++) begin
      waitTick();
      #1;
      if (t == abort_tick) begin
        reset = 1'b1;
        rx    = 1'b1;
        #1;
        checkOutput("abort_dout", {24'd0, dout}, 32'h00);
        checkOutput("abort_err", {31'd0, frame_err}, 32'h0);
        checkOutput("abort_done", {31'd0, rx_done_tick}, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        return;
      end
      if (t < 16)                     lvl = 1'b0;
      else if (t < 144)               lvl = data[(t - 16) / 16];
      else if (stop_low && t <= 152)  lvl = 1'b0;
      else                            lvl = 1'b1;
      if (t == corrupt_tick) lvl = ~lvl;
      rx = lvl;
    end
  endtask

  task automatic checkFrame(input string tag, input int pulses, input logic [7:0] data, input logic err);
    checkOutput({tag, "_pulses"}, pulses, pulse_count);
    checkOutput({tag, "_dout"}, {24'd0, last_dout}, {24'd0, data});
    checkOutput({tag, "_err"}, {31'd0, last_err}, {31'd0, err});
  endtask

  initial begin
    vector_count     = 0;
    miscompare_count = 0;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("reset_dout", {24'd0, dout}, 32'h00);
    checkOutput("reset_err", {31'd0, frame_err}, 32'h0);
    checkOutput("reset_done", {31'd0, rx_done_tick}, 32'h0);
    reset = 1'b0;
    idleTicks(4);
    checkOutput("idle_pulses", pulse_count, 0);

    applyStimulus(8'hA5, 1'b0, -1, -1);
    checkFrame("a5", 1, 8'hA5, 1'b0);
    checkOutput("a5_latency", 32'(pulse_time - t0), 32'd6085);

    // Start bit that lasts only 4 ticks must be dropped.
    waitTick();
    #1 rx = 1'b0;
    idleTicks(4);
    #1 rx = 1'b1;
    idleTicks(20);
    checkOutput("glitch_pulses", pulse_count, 1);
    checkOutput("glitch_dout", {24'd0, dout}, 32'hA5);

    applyStimulus(8'h3C, 1'b0, -1, -1);
    checkFrame("3c", 2, 8'h3C, 1'b0);

    applyStimulus(8'h5A, 1'b1, -1, -1);
    idleTicks(20);
    checkFrame("5a", 3, 8'h5A, 1'b1);
    checkOutput("5a_err_held", {31'd0, frame_err}, 32'h1);

    applyStimulus(8'h01, 1'b0, -1, -1);
    checkFrame("01", 4, 8'h01, 1'b0);

    applyStimulus(8'h00, 1'b0, -1, -1);
    checkFrame("b2b_00", 5, 8'h00, 1'b0);
    applyStimulus(8'hFF, 1'b0, -1, -1);
    checkFrame("b2b_ff", 6, 8'hFF, 1'b0);
    applyStimulus(8'h81, 1'b0, -1, -1);
    checkFrame("b2b_81", 7, 8'h81, 1'b0);

    applyStimulus(8'hC3, 1'b0, -1, 88);
    idleTicks(20);
    checkOutput("abort_pulses", pulse_count, 7);

    applyStimulus(8'h7E, 1'b0, -1, -1);
    checkFrame("7e", 8, 8'h7E, 1'b0);

    // Data bit 2 decision is tick 56; rx set at tick 55 is what that tick samples.
    applyStimulus(8'h0F, 1'b0, 55, -1);
`ifdef UART_RX_MAJORITY_EN
    checkFrame("vote_0f", 9, 8'h0F, 1'b0);
`else
    checkFrame("vote_0f", 9, 8'h0B, 1'b0);
`endif

    idleTicks(4);
    checkOutput("final_pulses", pulse_count, 9);
    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
